tick_sched: RTL
===============

# tick_sched

Programmable tick scheduler that sequences the divider counter: accepts a configuration (period, mode, tick count) over a valid/ready handshake, then runs a period counter producing single-cycle `tick` pulses in free-run, one-shot or burst mode. Supports hold and stop, and signals completion. It sits between a control master (FSM or register interface) and any logic that consumes periodic enables.

## Interface
- `BITS`, default 8: width of the period counter and `cfg_period`.
- `CNT_W`, default 4: width of the burst count and `ticks_left`.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  configuration can be accepted; high exactly when the state is IDLE.
- `cfg_period`  in  BITS  tick period P in cycles.
- `cfg_mode`  in  2  run mode: 00 free-run, 01 one-shot, 10 burst, 11 behaves as 00.
- `cfg_count`  in  CNT_W  number of ticks in burst mode.
- `hold`  in  1  freezes the period counter while in RUN.
- `stop`  in  1  aborts the run.
- `tick`  out  1  one-cycle enable pulse.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after the last tick of a one-shot or burst run.
- `ticks_left`  out  CNT_W  remaining ticks; 0 in free-run and IDLE.

## Operation
- Two states, IDLE and RUN. State is held in registers; `cfg_ready`, `busy` and `tick` decode from registers only.
- **Reset values:** state IDLE, `cnt`=0, `ticks_left`=0, `done`=0. This gives `cfg_ready`=1, `busy`=0 and `tick`=0.
- **Accept:** in IDLE, an edge with `cfg_valid`=1 latches the configuration.
  - `Pe` = max(`cfg_period`, 1). A period of 0 is treated as 1.
  - `ticks_left` loads `cfg_count` in burst mode, 1 in one-shot mode, 0 in free-run mode.
  - `cnt` clears to 0.
  - The state goes to RUN, except burst with `cfg_count`=0: it stays IDLE and `done` pulses in the next cycle, with no ticks.
  - Input `stop` is ignored in IDLE.
- **RUN:**
  - `tick` = RUN && !`hold` && `cnt`==`Pe`-1.
  - Each edge with `hold`=0: `cnt` ← (`cnt`==`Pe`-1) ? 0 : `cnt`+1. Width is BITS and there is no overflow, since `cnt` ≤ `Pe`-1.
  - `hold`=1: `cnt`, `ticks_left` and state are all frozen, and `tick`=0.
  - On a tick edge in one-shot or burst mode, `ticks_left` decrements. If `ticks_left` was 1, the state goes to IDLE, `cnt` clears, and `done`=1 for the next cycle only.
  - Free-run continues until `stop`.
- **Stop:** `stop`=1 sampled in RUN forces IDLE and clears `cnt` and `ticks_left`. Stop has priority over completion: no `done` pulse, even if the final tick is in the same cycle. A `tick` already high in that cycle is still seen by consumers.
- **Reconfiguration:** not possible in RUN, because `cfg_ready`=0. Configuration inputs are don't-care unless accepted.
- **Back-to-back runs:** the cycle in which `done`=1 is an IDLE cycle with `cfg_ready`=1, so a new configuration may be accepted in that same cycle.

## Timing
- Accept at edge E0. The first `tick` is high in the cycle after edge E0+`Pe`-1; with `Pe`=1 that is the cycle right after E0. Subsequent ticks are `Pe` cycles apart, plus any hold cycles.
- A burst of N ticks has `done` high in the cycle after the Nth tick. `busy` falls in that same cycle.
- `stop` takes effect at the next edge. `busy`=0 and `tick`=0 from the following cycle.
- `rst` asserted mid-run clears everything immediately (asynchronous). `tick` and `busy` drop without waiting for a clock edge, and no `done` is produced.
- `hold` acts on the same cycle for `tick` (combinational suppression) and on the next edge for state.

## Test plan
- Reset, then accept `cfg_period`=4, mode 10, `cfg_count`=3 -> ticks in the 4th, 8th and 12th cycles after acceptance; `ticks_left` reads 3,2,1,0; `done` in the 13th cycle; `cfg_ready`=1 from the 13th cycle.
- Free-run with `cfg_period`=0 and with 1 -> `tick` high every cycle after acceptance. Then `stop` -> `busy` low on the next cycle and no `done`.
- One-shot with `cfg_period`=5, and `hold` high for 3 cycles starting in the 2nd cycle -> single tick delayed to the 8th cycle, then `done` in the 9th.
- Burst with `cfg_count`=0 -> no tick, `busy` stays 0, `done` pulses in the cycle after acceptance. Burst with `cfg_count`=2 and `stop` in the final tick cycle -> tick seen, no `done`.
- Back-to-back: `cfg_valid` held high through the `done` cycle -> new configuration accepted in that cycle; `cfg_valid` ignored while `busy`=1.
- Async `rst` pulse between edges during RUN with `cnt`=2 -> `tick`, `busy` and `ticks_left` become 0 immediately; next acceptance starts from `cnt`=0.

Source files
------------

// File: rtl/tick_sched.sv
// Programmable tick scheduler: a configurable period counter that emits single-cycle
// tick enables in free-run, one-shot or burst mode, with hold, stop and completion pulse.
module tick_sched #(
  parameter int BITS  = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [BITS-1:0]  cfg_period,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             hold,
  input  logic             stop,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ticks_left
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_ONESHOT = 2'b01;
  localparam logic [1:0] MODE_BURST   = 2'b10;

  state_t           state, state_n;
  logic [BITS-1:0]  cnt, cnt_n;
  logic [BITS-1:0]  pe, pe_n;
  logic [CNT_W-1:0] left_n;
  logic             done_n;
  logic             at_end;

  // A zero period would never match cnt == pe-1 sensibly; treat it as one.
  function automatic logic [BITS-1:0] clamp_period(input logic [BITS-1:0] p);
    return (p == '0) ? BITS'(1) : p;
  endfunction

  assign at_end    = (cnt == pe - BITS'(1));
  assign tick      = (state == RUN) && !hold && at_end;
  assign busy      = (state == RUN);
  assign cfg_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ticks_left <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      ticks_left <= left_n;
      done       <= done_n;
    end
  end

  // The latched period is only consulted in RUN, which always follows a load.
  always_ff @(posedge clk) begin
    pe <= pe_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    left_n  = ticks_left;
    done_n  = 1'b0;
    pe_n    = pe;
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          pe_n  = clamp_period(cfg_period);
          cnt_n = '0;
          case (cfg_mode)
            MODE_ONESHOT: left_n = CNT_W'(1);
            MODE_BURST:   left_n = cfg_count;
            default:      left_n = '0;
          endcase
          // An empty burst completes immediately without ever entering RUN.
          if (cfg_mode == MODE_BURST && cfg_count == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          cnt_n   = '0;
          left_n  = '0;
        end else if (!hold) begin
          if (at_end) begin
            cnt_n = '0;
            // Free-run carries ticks_left == 0, so a nonzero count marks a counted run.
            if (ticks_left != '0) begin
              left_n = ticks_left - CNT_W'(1);
              if (ticks_left == CNT_W'(1)) begin
                state_n = IDLE;
                done_n  = 1'b1;
              end
            end
          end else begin
            cnt_n = cnt + BITS'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
